// File: rtl/dm_rmw_pkg.sv
// Shared definitions for the data memory load/store sequencer.
package dm_rmw_pkg;
   localparam int unsigned DM_ADDR_W = 10;
   localparam int unsigned DM_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MERGE = 2'd1,
      ST_LOAD  = 2'd2
   } dm_state_e;
endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, read-first, no reset on the array.
module ram_sp
   import dm_rmw_pkg::*;
#(
   parameter int unsigned ADDR_W = DM_ADDR_W,
   parameter int unsigned DATA_W = DM_DATA_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Non-blocking read returns the pre-write contents on a same-index write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[idx] <= wdata;
      end
      rdata_q <= mem_q[idx];
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/dm_rmw.sv
// Data memory with load/store sequencer; stalls for sb read-modify-write and loads.
module dm_rmw
   import dm_rmw_pkg::*;
#(
   parameter int unsigned ADDR_W = DM_ADDR_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic        sb,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        stall
);
   dm_state_e         state_q, state_d;
   logic              rd_valid_q, rd_valid_d;
   logic              ram_we;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       ram_rdata;
   logic              unused_addr;

   assign idx         = addr[ADDR_W+1:2];
   assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

   ram_sp #(
      .ADDR_W (ADDR_W),
      .DATA_W (32)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .idx   (idx),
      .wdata (din),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // The RAM output register has no reset, so a reset edge blanks it here instead.
   assign dout = rd_valid_q ? ram_rdata : 32'd0;

   always_comb begin
      state_d    = state_q;
      stall      = 1'b0;
      ram_we     = 1'b0;
      rd_valid_d = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            if (MemWr) begin
               if (sb) begin
                  stall   = 1'b1;
                  state_d = ST_MERGE;
               end else begin
                  ram_we = 1'b1;
               end
            end else if (MemRd) begin
               stall   = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_MERGE: begin
            ram_we  = 1'b1;
            state_d = ST_IDLE;
         end
         ST_LOAD: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Reset aborts any pending merge write and masks stall.
      if (reset) begin
         state_d    = ST_IDLE;
         stall      = 1'b0;
         ram_we     = 1'b0;
         rd_valid_d = 1'b0;
      end
   end
endmodule

// File: tb/tb_dm_rmw.sv
// Scoreboard bench for dm_rmw with a byte-merge unit modelled alongside it.
module tb_dm_rmw;
   logic        clk = 1'b0;
   logic        reset;
   logic        MemRd, MemWr, sb;
   logic [31:0] addr, busb, din_w, dout;
   logic        stall;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model [int];
   bit          ld_wait = 0;
   bit          prev_stall = 0;
   logic [34:0] prev_in;

   always #5 clk = ~clk;

   dm_rmw #(.ADDR_W(10)) dut (
      .clk   (clk),
      .reset (reset),
      .MemRd (MemRd),
      .MemWr (MemWr),
      .sb    (sb),
      .addr  (addr),
      .din   (din_w),
      .dout  (dout),
      .stall (stall)
   );

   function automatic logic [31:0] mu_merge(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [7:0] b);
      logic [31:0] r;
      r = w;
      case (lane)
         2'd0: r[7:0]   = b;
         2'd1: r[15:8]  = b;
         2'd2: r[23:16] = b;
         default: r[31:24] = b;
      endcase
      return r;
   endfunction

   // Byte-store merge unit sitting next to the memory in the datapath.
   always_comb begin
      din_w = busb;
      if (MemWr && sb) din_w = mu_merge(dout, addr[1:0], busb[7:0]);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else n_pass++;
   endtask

   function automatic int word_key(input logic [31:0] a);
      return int'((a >> 2) % 1024);
   endfunction

   // kind: 0 sw, 1 sb, 2 lw, 3 sw with MemRd also raised
   task automatic do_op(input int kind, input logic [31:0] a, input logic [31:0] d);
      int n;
      bit s;
      int key;
      int sh;
      key   = word_key(a);
      MemWr = (kind != 2);
      MemRd = (kind >= 2);
      sb    = (kind == 1);
      addr  = a;
      busb  = d;
      sh    = 8 * int'(a % 4);
      if (kind == 0 || kind == 3) model[key] = d;
      else if (kind == 1) model[key] = (model[key] & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      else exp_q.push_back(model.exists(key) ? model[key] : 32'd0);
      n = 0;
      forever begin
         @(negedge clk);
         s = stall;
         @(posedge clk);
         #1;
         if (!s) break;
         n++;
         if (n > 8) begin
            $display("FAIL op_timeout: got %0d stall cycles expected at most 1", n);
            n_chk++;
            break;
         end
      end
      chk("stall_cycles", 32'(n), (kind == 1 || kind == 2) ? 32'd1 : 32'd0);
      MemWr = 1'b0;
      MemRd = 1'b0;
      sb    = 1'b0;
   endtask

   // Monitor: a load presents its data in the first non-stalled cycle after its stall.
   always @(negedge clk) begin
      if (reset) begin
         ld_wait = 0;
      end else if (ld_wait && !stall) begin
         if (exp_q.size() == 0) chk("load_unexpected", dout, 32'hxxxxxxxx);
         else chk("load_data", dout, exp_q.pop_front());
         ld_wait = 0;
      end else if (MemRd && !MemWr && stall) begin
         ld_wait = 1;
      end
   end

   // CPU-side contract: request inputs stay put while stalled.
   always @(negedge clk) begin
      if (prev_stall && {MemRd, MemWr, sb, addr} !== prev_in)
         $error("request inputs changed while stalled");
      prev_in    = {MemRd, MemWr, sb, addr};
      prev_stall = stall && !reset;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      reset = 1'b1;
      MemRd = 1'b1;
      MemWr = 1'b0;
      sb    = 1'b0;
      addr  = 32'h10;
      busb  = 32'h0;
      @(posedge clk);
      repeat (3) begin
         @(negedge clk);
         chk("reset_stall", 32'(stall), 32'd0);
         chk("reset_dout", dout, 32'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      MemRd = 1'b0;

      // sw then lw
      do_op(0, 32'h10, 32'hDEADBEEF);
      do_op(2, 32'h10, 32'h0);

      // single sb through the merge unit
      do_op(0, 32'h10, 32'h11223344);
      do_op(1, 32'h12, 32'h000000AB);
      do_op(2, 32'h10, 32'h0);
      chk("sb_model", model[4], 32'h11AB3344);

      // back-to-back sb
      do_op(0, 32'h10, 32'h11223344);
      do_op(1, 32'h10, 32'h000000AA);
      do_op(1, 32'h13, 32'h000000BB);
      do_op(2, 32'h10, 32'h0);
      chk("b2b_model", model[4], 32'hBB2233AA);

      // reset during MERGE drops the write
      do_op(0, 32'h20, 32'h55555555);
      MemWr = 1'b1;
      sb    = 1'b1;
      addr  = 32'h20;
      busb  = 32'h00000012;
      @(negedge clk);
      chk("abort_idle_stall", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_merge_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      MemWr = 1'b0;
      sb    = 1'b0;
      @(negedge clk);
      chk("abort_after_stall", 32'(stall), 32'd0);
      chk("abort_after_dout", dout, 32'd0);
      @(posedge clk);
      #1;
      do_op(2, 32'h20, 32'h0);

      // MemWr with MemRd: store wins, no load
      do_op(3, 32'h30, 32'hCAFEF00D);
      @(negedge clk);
      chk("wr_rd_idle_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      do_op(2, 32'h30, 32'h0);

      // upper address bits alias onto the same word
      do_op(0, 32'h0001_0010, 32'h0BADF00D);
      do_op(2, 32'h10, 32'h0);

      // randomized mix over a small word window
      for (int i = 0; i < 8; i++) do_op(0, 32'(32'h100 + 4 * i), $urandom);
      for (int i = 0; i < 200; i++) begin
         a = ($urandom & 32'hFFFF_F000) | 32'(32'h100 + 4 * $urandom_range(0, 7))
             | 32'($urandom_range(0, 3));
         do_op(int'($urandom_range(0, 3)), a, $urandom);
      end

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
